// File: rtl/dma_copy_host.sv
// Single-channel word-copy DMA: a register port programs SRC/DST/LEN, and the
// initiator port performs one read followed by one write per word.
module dma_copy_host #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 device_req_i,
  input  logic [AddrWidth-1:0] device_addr_i,
  input  logic                 device_we_i,
  input  logic [3:0]           device_be_i,
  input  logic [DataWidth-1:0] device_wdata_i,
  output logic                 device_rvalid_o,
  output logic [DataWidth-1:0] device_rdata_o,
  output logic                 host_req_o,
  input  logic                 host_gnt_i,
  output logic [AddrWidth-1:0] host_addr_o,
  output logic                 host_we_o,
  output logic [3:0]           host_be_o,
  output logic [DataWidth-1:0] host_wdata_o,
  input  logic                 host_rvalid_i,
  input  logic [DataWidth-1:0] host_rdata_i,
  input  logic                 host_err_i,
  output logic                 irq_o,
  output logic [2:0]           dbg_state_o
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_WAIT = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   src_q, dst_q, wsrc_q, wdst_q;
  logic [15:0]            len_q, wcnt_q;
  logic [31:0]            buf_q;
  logic                   done_q, err_q, irq_q;
  logic                   dev_rvalid_q;
  logic [31:0]            dev_rdata_q;

  logic [1:0]  reg_sel;
  logic [31:0] wdata32, rd_word, src_m, dst_m, len_m;
  logic        busy, reg_wr, cfg_wr, ctrl_wr, start_req, clear_req;
  logic        load_work, capture, advance, set_done, set_err;
  logic        unused_addr_bits;

  function automatic logic [31:0] be_merge(input logic [31:0] old_w,
                                           input logic [31:0] new_w,
                                           input logic [3:0]  be);
    be_merge = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) be_merge[8*b +: 8] = new_w[8*b +: 8];
    end
  endfunction

  assign reg_sel          = device_addr_i[3:2];
  assign unused_addr_bits = ^{device_addr_i[AddrWidth-1:4], device_addr_i[1:0]};
  assign wdata32          = device_wdata_i;
  assign busy             = (state_q != ST_IDLE);
  assign reg_wr           = device_req_i && device_we_i;
  assign cfg_wr           = reg_wr && !busy && (reg_sel != 2'd3);
  assign ctrl_wr          = reg_wr && (reg_sel == 2'd3) && device_be_i[0];
  assign start_req        = ctrl_wr && wdata32[0];
  assign clear_req        = ctrl_wr && wdata32[1];

  assign src_m = be_merge(32'(src_q), wdata32, device_be_i);
  assign dst_m = be_merge(32'(dst_q), wdata32, device_be_i);
  assign len_m = be_merge({16'h0, len_q}, wdata32, device_be_i);

  always_comb begin
    rd_word = '0;
    unique case (reg_sel)
      2'd0:    rd_word = 32'(src_q);
      2'd1:    rd_word = 32'(dst_q);
      2'd2:    rd_word = {16'h0, len_q};
      default: rd_word = {29'h0, err_q, done_q, busy};
    endcase
  end

  // Initiator handshake: a transfer is accepted on a cycle where host_req_o
  // and host_gnt_i are both high; address/we/wdata are pure functions of the
  // request state, so they cannot move while the request is stalled. Exactly
  // one host_rvalid_i is expected per accepted transfer and only one is ever
  // outstanding.
  always_comb begin
    state_d   = state_q;
    load_work = 1'b0;
    capture   = 1'b0;
    advance   = 1'b0;
    set_done  = 1'b0;
    set_err   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_req) begin
          if (len_q != 16'h0) begin
            state_d   = ST_RD_REQ;
            load_work = 1'b1;
          end else begin
            set_done = 1'b1;
          end
        end
      end
      ST_RD_REQ: if (host_gnt_i) state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (host_rvalid_i) begin
          if (host_err_i) begin
            state_d = ST_IDLE;
            set_err = 1'b1;
          end else begin
            state_d = ST_WR_REQ;
            capture = 1'b1;
          end
        end
      end
      ST_WR_REQ: if (host_gnt_i) state_d = ST_WR_WAIT;
      ST_WR_WAIT: begin
        if (host_rvalid_i) begin
          if (host_err_i) begin
            state_d = ST_IDLE;
            set_err = 1'b1;
          end else begin
            advance = 1'b1;
            if (wcnt_q == 16'd1) begin
              state_d  = ST_IDLE;
              set_done = 1'b1;
            end else begin
              state_d = ST_RD_REQ;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      wsrc_q       <= '0;
      wdst_q       <= '0;
      wcnt_q       <= '0;
      buf_q        <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      irq_q        <= 1'b0;
      dev_rvalid_q <= 1'b0;
      dev_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      irq_q        <= set_done || set_err;
      dev_rvalid_q <= device_req_i;
      dev_rdata_q  <= (device_req_i && !device_we_i) ? rd_word : 32'h0;
      if (cfg_wr) begin
        unique case (reg_sel)
          2'd0:    src_q <= {src_m[AddrWidth-1:2], 2'b00};
          2'd1:    dst_q <= {dst_m[AddrWidth-1:2], 2'b00};
          default: len_q <= len_m[15:0];
        endcase
      end
      // Clear is applied before start/set so clear+start behaves as clear-then-start.
      if (clear_req || load_work) begin
        done_q <= 1'b0;
        err_q  <= 1'b0;
      end
      if (set_done) done_q <= 1'b1;
      if (set_err)  err_q  <= 1'b1;
      if (load_work) begin
        wsrc_q <= src_q;
        wdst_q <= dst_q;
        wcnt_q <= len_q;
      end
      if (capture) buf_q <= host_rdata_i;
      if (advance) begin
        wsrc_q <= wsrc_q + AddrWidth'(4);
        wdst_q <= wdst_q + AddrWidth'(4);
        wcnt_q <= wcnt_q - 16'd1;
      end
    end
  end

  assign host_req_o      = (state_q == ST_RD_REQ) || (state_q == ST_WR_REQ);
  assign host_we_o       = (state_q == ST_WR_REQ);
  assign host_be_o       = 4'hF;
  assign host_addr_o     = (state_q == ST_RD_REQ) ? wsrc_q :
                           (state_q == ST_WR_REQ) ? wdst_q : '0;
  assign host_wdata_o    = (state_q == ST_WR_REQ) ? buf_q : '0;
  assign device_rvalid_o = dev_rvalid_q;
  assign device_rdata_o  = dev_rdata_q;
  assign irq_o           = irq_q;
  assign dbg_state_o     = state_q;

endmodule

// File: doc/dma_copy_host.md
DMA_COPY_HOST -- requirements
Module: dma_copy_host

Interface
REQ-001 Parameter AddrWidth, default 32, bus address width.
REQ-002 Parameter DataWidth, default 32, bus data width; only 32 is supported.
REQ-003 clk_i  input  1  system clock, single clock domain.
REQ-004 rst_i  input  1  reset, synchronous and active-high.
REQ-005 device_req_i  input  1  register-port request from the bus.
REQ-006 device_addr_i  input  AddrWidth  register-port address; bits [3:2] decode the register.
REQ-007 device_we_i  input  1  register-port write enable.
REQ-008 device_be_i  input  4  register-port byte enables.
REQ-009 device_wdata_i  input  32  register-port write data.
REQ-010 device_rvalid_o  output  1  register-port response valid.
REQ-011 device_rdata_o  output  32  register-port read data.
REQ-012 host_req_o  output  1  initiator request.
REQ-013 host_gnt_i  input  1  initiator grant.
REQ-014 host_addr_o  output  AddrWidth  initiator address, word-aligned.
REQ-015 host_we_o  output  1  initiator write enable.
REQ-016 host_be_o  output  4  initiator byte enables; always 4'hF.
REQ-017 host_wdata_o  output  32  initiator write data.
REQ-018 host_rvalid_i  input  1  initiator response valid.
REQ-019 host_rdata_i  input  32  initiator read data.
REQ-020 host_err_i  input  1  initiator error; qualified by host_rvalid_i.
REQ-021 irq_o  output  1  done/error interrupt, one-cycle pulse.

Function
REQ-022 Register map (word offsets):
- 0x0 SRC: source address.
- 0x4 DST: destination address.
- 0x8 LEN: word count, 16 bits.
- 0xC CTRL/STATUS:
  - write: bit0 = start, bit1 = clear done/err (write-1).
  - read: bit0 = busy, bit1 = done, bit2 = err.
REQ-023 Register writes SHALL update only bytes whose device_be_i bit is set; SRC/DST bits [1:0] are stored as 0.
REQ-024 device_rvalid_o SHALL assert exactly one cycle after every device_req_i, for reads and writes alike.
REQ-025 device_rdata_o SHALL be valid while device_rvalid_o is high; it reads 0 for write responses.
REQ-026 Writes to SRC, DST or LEN while busy SHALL be ignored; they still receive a response.
REQ-027 FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT.
REQ-028 IDLE->RD_REQ on a start write with LEN!=0: latches working src/dst/count, sets busy, clears done/err.
REQ-029 Start with LEN==0 SHALL stay in IDLE, set done and pulse irq_o in the following cycle.
REQ-030 RD_REQ: host_req_o=1, host_we_o=0, host_addr_o=src; go to RD_WAIT on host_gnt_i.
REQ-031 RD_WAIT: on host_rvalid_i, capture host_rdata_i into the data buffer and go to WR_REQ; if host_err_i, go to IDLE with err=1.
REQ-032 WR_REQ: host_req_o=1, host_we_o=1, host_addr_o=dst, host_wdata_o=buffer; go to WR_WAIT on host_gnt_i.
REQ-033 WR_WAIT: on host_rvalid_i, src+=4, dst+=4, count-=1.
- If count reaches 0: go to IDLE with done=1.
- Otherwise: go to RD_REQ.
- If host_err_i: go to IDLE with err=1.
REQ-034 While host_req_o is high and host_gnt_i is low, host_addr_o, host_we_o and host_wdata_o SHALL be held stable.
REQ-035 host_req_o SHALL deassert in the cycle after a grant; at most one transaction is outstanding.
REQ-036 Address increments SHALL wrap modulo 2^AddrWidth without error.
REQ-037 irq_o SHALL pulse one cycle on every transition into done or err.
REQ-038 A start write while busy SHALL be ignored.
REQ-039 Clear (bit1) together with start (bit0) in the same write SHALL clear status first, then start.
REQ-040 A host_rvalid_i received outside RD_WAIT/WR_WAIT SHALL be ignored.

Reset
REQ-041 While rst_i is high at a clock edge, the following SHALL be 0 after that edge:
- FSM state (IDLE), SRC, DST, LEN, status bits;
- host_req_o, host_we_o, host_addr_o, host_wdata_o;
- device_rvalid_o, device_rdata_o, irq_o.
REQ-042 host_be_o SHALL read 4'hF at all times, including during reset.
REQ-043 Reset asserted mid-transfer SHALL abort immediately; host_req_o drops after that edge and no done/irq is produced.

Verification
REQ-044 SRC=0x00100000, DST=0x00100100, LEN=4, start, zero-wait memory -> 4 read/write pairs, DST words equal SRC words, done=1, one irq_o pulse, busy=0.
REQ-045 host_gnt_i delayed 3 cycles on every request -> host_addr_o/we/wdata stable during the stall, copy correct.
REQ-046 LEN=0, start -> no host_req_o, STATUS reads 0x2, one irq_o pulse.
REQ-047 host_err_i on the second read response -> STATUS reads 0x4, exactly one write issued, irq_o pulses once.
REQ-048 SRC=0xFFFFFFFC, LEN=2 -> second read address 0x00000000.
REQ-049 rst_i asserted during WR_WAIT -> all outputs 0 (host_be_o 4'hF) on the next cycle; a fresh start afterwards completes normally.
